cache_ctrl: RTL and testbench
=============================

# cache_ctrl

Sequencing controller for the 32-line direct-mapped processor cache (8-bit tag, 64-bit line of four 16-bit words, valid and dirty bits per line). It accepts single-word CPU read and write requests and drives the cache array's index, tag, line, dirty and write-enable inputs. On a miss it runs write-back of a dirty victim and a four-beat line fill over a 16-bit handshaked memory port. Policy is write-back, write-allocate.

## Interface
Parameters: none. Fixed geometry:
- Byte address split: `tag = addr[15:8]`, `index = addr[7:3]`, `word = addr[2:1]`; `addr[0]` is ignored.
- Word w occupies line bits `[16w+15:16w]`.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- cpuReq  in  1  request strobe; sampled only in IDLE.
- cpuWr  in  1  1 = write, 0 = read; sampled with cpuReq.
- cpuAddr  in  16  byte address; sampled with cpuReq.
- cpuWdata  in  16  write data; sampled with cpuReq.
- cpuRdata  out  16  read data, registered; valid while cpuDone = 1.
- cpuDone  out  1  one-cycle completion pulse, registered.
- cacheIndex  out  5  array index (read and write).
- cacheTag  out  8  tag to write.
- cacheBlock  out  64  line to write.
- cacheDirty  out  1  dirty bit to write.
- cacheWr  out  1  array write enable. The valid bit is written as 1.
- cacheOutTag  in  8  tag at cacheIndex (combinational read).
- cacheOutBlock  in  64  line at cacheIndex.
- cacheOutValid  in  1  valid bit at cacheIndex.
- cacheOutDirty  in  1  dirty bit at cacheIndex.
- memReq  out  1  memory beat request.
- memWr  out  1  1 = beat is a write.
- memAddr  out  16  byte address of beat; bit 0 = 0.
- memWdata  out  16  write-beat data.
- memRdata  in  16  read-beat data; valid with memAck.
- memAck  in  1  beat completes on a cycle with memReq & memAck.

## Operation
- Request latch: on IDLE & cpuReq, store `reqWr`, `reqTag`, `reqIdx`, `reqWord` and `reqData`, then go to LOOKUP. `cacheIndex = reqIdx` in every state except IDLE. In IDLE it is `cpuAddr[7:3]`.
- LOOKUP: `hit = cacheOutValid & (cacheOutTag == reqTag)`.
  - Read hit: `cpuRdata <=` word `reqWord` of cacheOutBlock; cpuDone pulses next cycle; go to IDLE.
  - Write hit: cacheWr = 1, cacheTag = reqTag, cacheBlock = cacheOutBlock with word `reqWord` replaced by reqData, cacheDirty = 1. cpuDone pulses next cycle; go to IDLE.
  - Miss with cacheOutValid & cacheOutDirty: capture cacheOutBlock and cacheOutTag into a victim buffer, beat counter = 0, go to EVICT.
  - Any other miss: beat counter = 0, go to FILL.
- EVICT: memReq = 1, memWr = 1, `memAddr = {victimTag, reqIdx, beat, 1'b0}`, memWdata = victim word `beat`. On memAck the beat counter increments. Ack of beat 3 moves to FILL with beat = 0.
- FILL: memReq = 1, memWr = 0, `memAddr = {reqTag, reqIdx, beat, 1'b0}`. On memAck, memRdata is written into fill-buffer word `beat`. Ack of beat 3 moves to INSTALL.
- INSTALL: cacheWr = 1, cacheTag = reqTag, cacheBlock = fill buffer, cacheDirty = 0. Then go to LOOKUP, which now hits and completes the request, including the write merge.
- cacheWr is 0 in every other state and condition. Outputs held in a beat stay stable until memAck.
- The 2-bit beat counter wraps 3 → 0 only on the state change.

## Timing
- Reset: state IDLE, beat = 0, all buffers 0. Every output is 0: cpuRdata, cpuDone, cacheWr, cacheTag, cacheBlock, cacheDirty, memReq, memWr, memAddr, memWdata. cacheIndex is 0, following cpuAddr in IDLE.
- The array's valid bits are cleared by the same reset event.
- Reset mid-operation aborts immediately. memReq is 0 from the next cycle. No cacheWr is issued and no cpuDone is raised for the aborted request.
- Hit latency: cpuReq in cycle 0, LOOKUP in cycle 1, cpuDone/cpuRdata in cycle 2. A new cpuReq is accepted in cycle 2, so back-to-back hits complete every 2 cycles.
- Clean miss with a one-cycle memAck: LOOKUP, FILL ×4, INSTALL, LOOKUP, then cpuDone. That is cpuDone in cycle 8.
- Dirty miss adds 4 EVICT cycles, so cpuDone is in cycle 12. Each memAck stall adds one cycle.
- cpuReq outside IDLE is ignored. The requester holds it until cpuDone.
- memAck while memReq = 0 is ignored.

## Test plan
- Reset, then read 0x1234 (tag 0x12, idx 6, word 2) → FILL beats at 0x1230, 0x1232, 0x1234, 0x1236. Memory returns 0xA0..0xA3, and cpuRdata = 0x00A2 in cycle 8.
- Write 0xBEEF to 0x1236 after the fill → hit. cacheWr with word 3 = 0xBEEF and dirty = 1; cpuDone in cycle 2; no memReq.
- Read 0x5634 (same idx 6, tag 0x56) → EVICT writes 0x00A0, 0x00A1, 0x00A2, 0xBEEF to 0x1230–0x1236, then FILL from 0x5630. cpuDone in cycle 12.
- memAck delayed by 3 cycles on every beat → memAddr and memWdata stay stable during each stall. Clean miss completes in cycle 20.
- Assert rst during FILL beat 2 → next cycle memReq = 0, cacheWr = 0, cpuDone = 0, state IDLE. A read of 0x1234 then misses.
- Pulse cpuReq during EVICT with a different address → ignored; the original request completes with its own data.

Source files
------------

// File: rtl/cache_ctrl_if.sv
// Bundled CPU, cache-array and memory-port signals of the direct-mapped cache controller.
// slave = controller side, master = CPU/array/memory environment side.
interface cache_ctrl_if;
  logic        cpuReq;
  logic        cpuWr;
  logic [15:0] cpuAddr;
  logic [15:0] cpuWdata;
  logic [15:0] cpuRdata;
  logic        cpuDone;

  logic [4:0]  cacheIndex;
  logic [7:0]  cacheTag;
  logic [63:0] cacheBlock;
  logic        cacheDirty;
  logic        cacheWr;
  logic [7:0]  cacheOutTag;
  logic [63:0] cacheOutBlock;
  logic        cacheOutValid;
  logic        cacheOutDirty;

  logic        memReq;
  logic        memWr;
  logic [15:0] memAddr;
  logic [15:0] memWdata;
  logic [15:0] memRdata;
  logic        memAck;

  modport slave (
    input  cpuReq, cpuWr, cpuAddr, cpuWdata,
    output cpuRdata, cpuDone,
    output cacheIndex, cacheTag, cacheBlock, cacheDirty, cacheWr,
    input  cacheOutTag, cacheOutBlock, cacheOutValid, cacheOutDirty,
    output memReq, memWr, memAddr, memWdata,
    input  memRdata, memAck
  );

  modport master (
    output cpuReq, cpuWr, cpuAddr, cpuWdata,
    input  cpuRdata, cpuDone,
    input  cacheIndex, cacheTag, cacheBlock, cacheDirty, cacheWr,
    output cacheOutTag, cacheOutBlock, cacheOutValid, cacheOutDirty,
    input  memReq, memWr, memAddr, memWdata,
    output memRdata, memAck
  );
endinterface

// File: rtl/cache_ctrl.sv
// Write-back, write-allocate sequencer for a 32-line direct-mapped cache with
// four-beat 16-bit line fill and dirty-victim write-back.
module cache_ctrl (
  input logic         clk,
  input logic         rst,
  cache_ctrl_if.slave bus
);
  typedef enum logic [2:0] {IDLE, LOOKUP, EVICT, FILL, INSTALL} state_e;

  state_e      state_q, state_d;
  logic [1:0]  beat_q, beat_d;
  logic        reqWr_q, reqWr_d;
  logic [7:0]  reqTag_q, reqTag_d;
  logic [4:0]  reqIdx_q, reqIdx_d;
  logic [1:0]  reqWord_q, reqWord_d;
  logic [15:0] reqData_q, reqData_d;
  logic [7:0]  victimTag_q, victimTag_d;
  logic [63:0] victimBlock_q, victimBlock_d;
  logic [63:0] fillBuf_q, fillBuf_d;
  logic [15:0] cpuRdata_q, cpuRdata_d;
  logic        cpuDone_q, cpuDone_d;
  logic        hit;
  logic [63:0] merged;
  logic        unused_addr0;

  assign unused_addr0 = bus.cpuAddr[0];
  assign hit          = bus.cacheOutValid & (bus.cacheOutTag == reqTag_q);
  assign bus.cpuRdata = cpuRdata_q;
  assign bus.cpuDone  = cpuDone_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      beat_q        <= '0;
      reqWr_q       <= 1'b0;
      reqTag_q      <= '0;
      reqIdx_q      <= '0;
      reqWord_q     <= '0;
      reqData_q     <= '0;
      victimTag_q   <= '0;
      victimBlock_q <= '0;
      fillBuf_q     <= '0;
      cpuRdata_q    <= '0;
      cpuDone_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      beat_q        <= beat_d;
      reqWr_q       <= reqWr_d;
      reqTag_q      <= reqTag_d;
      reqIdx_q      <= reqIdx_d;
      reqWord_q     <= reqWord_d;
      reqData_q     <= reqData_d;
      victimTag_q   <= victimTag_d;
      victimBlock_q <= victimBlock_d;
      fillBuf_q     <= fillBuf_d;
      cpuRdata_q    <= cpuRdata_d;
      cpuDone_q     <= cpuDone_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    beat_d         = beat_q;
    reqWr_d        = reqWr_q;
    reqTag_d       = reqTag_q;
    reqIdx_d       = reqIdx_q;
    reqWord_d      = reqWord_q;
    reqData_d      = reqData_q;
    victimTag_d    = victimTag_q;
    victimBlock_d  = victimBlock_q;
    fillBuf_d      = fillBuf_q;
    cpuRdata_d     = cpuRdata_q;
    cpuDone_d      = 1'b0;
    merged         = bus.cacheOutBlock;
    merged[{reqWord_q, 4'b0000} +: 16] = reqData_q;

    bus.cacheIndex = reqIdx_q;
    bus.cacheTag   = '0;
    bus.cacheBlock = '0;
    bus.cacheDirty = 1'b0;
    bus.cacheWr    = 1'b0;
    bus.memReq     = 1'b0;
    bus.memWr      = 1'b0;
    bus.memAddr    = '0;
    bus.memWdata   = '0;

    unique case (state_q)
      IDLE: begin
        bus.cacheIndex = bus.cpuAddr[7:3];
        if (bus.cpuReq) begin
          reqWr_d   = bus.cpuWr;
          reqTag_d  = bus.cpuAddr[15:8];
          reqIdx_d  = bus.cpuAddr[7:3];
          reqWord_d = bus.cpuAddr[2:1];
          reqData_d = bus.cpuWdata;
          state_d   = LOOKUP;
        end
      end
      LOOKUP: begin
        beat_d = '0;
        if (hit) begin
          if (reqWr_q) begin
            bus.cacheWr    = 1'b1;
            bus.cacheTag   = reqTag_q;
            bus.cacheBlock = merged;
            bus.cacheDirty = 1'b1;
          end else begin
            cpuRdata_d = bus.cacheOutBlock[{reqWord_q, 4'b0000} +: 16];
          end
          cpuDone_d = 1'b1;
          state_d   = IDLE;
        end else if (bus.cacheOutValid & bus.cacheOutDirty) begin
          victimTag_d   = bus.cacheOutTag;
          victimBlock_d = bus.cacheOutBlock;
          state_d       = EVICT;
        end else begin
          state_d = FILL;
        end
      end
      EVICT: begin
        bus.memReq   = 1'b1;
        bus.memWr    = 1'b1;
        bus.memAddr  = {victimTag_q, reqIdx_q, beat_q, 1'b0};
        bus.memWdata = victimBlock_q[{beat_q, 4'b0000} +: 16];
        if (bus.memAck) begin
          beat_d = beat_q + 2'd1;
          if (beat_q == 2'd3) state_d = FILL;
        end
      end
      FILL: begin
        bus.memReq  = 1'b1;
        bus.memAddr = {reqTag_q, reqIdx_q, beat_q, 1'b0};
        if (bus.memAck) begin
          fillBuf_d[{beat_q, 4'b0000} +: 16] = bus.memRdata;
          beat_d = beat_q + 2'd1;
          if (beat_q == 2'd3) state_d = INSTALL;
        end
      end
      INSTALL: begin
        // Re-enter LOOKUP so the hit path performs the read return or write merge.
        bus.cacheWr    = 1'b1;
        bus.cacheTag   = reqTag_q;
        bus.cacheBlock = fillBuf_q;
        state_d        = LOOKUP;
      end
      default: state_d = IDLE;
    endcase
  end
endmodule

// File: tb/tb_cache_ctrl.sv
// Directed bench for cache_ctrl: behavioural cache array, stallable memory
// responder with beat log, and latency/data checks on each request.
module tb_cache_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  cache_ctrl_if bus();
  cache_ctrl dut (.clk(clk), .rst(rst), .bus(bus));

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Cache array model: combinational read, write on clock edge
  logic [7:0]  c_tag   [0:31];
  logic [63:0] c_block [0:31];
  logic        c_valid [0:31];
  logic        c_dirty [0:31];
  int          wr_count = 0;
  logic [63:0] last_block;
  logic [7:0]  last_tag;
  logic        last_dirty;

  assign bus.cacheOutTag   = c_tag[bus.cacheIndex];
  assign bus.cacheOutBlock = c_block[bus.cacheIndex];
  assign bus.cacheOutValid = c_valid[bus.cacheIndex];
  assign bus.cacheOutDirty = c_dirty[bus.cacheIndex];

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) begin
        c_valid[i] <= 1'b0;
        c_dirty[i] <= 1'b0;
        c_tag[i]   <= '0;
        c_block[i] <= '0;
      end
    end else if (bus.cacheWr) begin
      c_tag[bus.cacheIndex]   <= bus.cacheTag;
      c_block[bus.cacheIndex] <= bus.cacheBlock;
      c_valid[bus.cacheIndex] <= 1'b1;
      c_dirty[bus.cacheIndex] <= bus.cacheDirty;
      wr_count   <= wr_count + 1;
      last_block <= bus.cacheBlock;
      last_tag   <= bus.cacheTag;
      last_dirty <= bus.cacheDirty;
    end
  end

  // Memory responder: read-only preload, ack after 'delay' stall cycles
  logic [15:0] mem [int];
  logic [32:0] beats [$];
  int          delay = 0;
  logic        check_stable = 1'b0;
  int          waitcnt = 0;
  int          memreq_cycles = 0;
  logic        ack_prev = 1'b0;
  logic [32:0] a_beat;
  logic [15:0] b_addr, b_wdata;

  always @(negedge clk) begin
    if (rst) begin
      bus.memAck   = 1'b0;
      bus.memRdata = '0;
      waitcnt      = 0;
      ack_prev     = 1'b0;
    end else begin
      if (ack_prev) begin
        beats.push_back(a_beat);
        waitcnt = 0;
      end
      ack_prev   = 1'b0;
      bus.memAck = 1'b0;
      if (bus.memReq) begin
        memreq_cycles++;
        if (waitcnt == 0) begin
          b_addr  = bus.memAddr;
          b_wdata = bus.memWdata;
        end else if (check_stable) begin
          check("stall_addr", 64'(bus.memAddr), 64'(b_addr));
          check("stall_wdata", 64'(bus.memWdata), 64'(b_wdata));
        end
        if (waitcnt == delay) begin
          bus.memAck   = 1'b1;
          bus.memRdata = mem.exists(int'(bus.memAddr[15:1])) ? mem[int'(bus.memAddr[15:1])] : 16'h0;
          ack_prev     = 1'b1;
          a_beat       = {bus.memWr, bus.memAddr, bus.memWdata};
        end else begin
          waitcnt++;
        end
      end
    end
  end

  task automatic do_req(input logic wr, input logic [15:0] addr, input logic [15:0] data,
                        input int poke, output int lat, output logic [15:0] rd);
    bus.cpuReq   = 1'b1;
    bus.cpuWr    = wr;
    bus.cpuAddr  = addr;
    bus.cpuWdata = data;
    lat = 0;
    rd  = '0;
    while (1) begin
      @(posedge clk);
      lat++;
      #1;
      if (bus.cpuDone) begin
        rd = bus.cpuRdata;
        bus.cpuReq = 1'b0;
        break;
      end
      if (lat >= 200) begin
        check("timeout", 64'(lat), 64'(0));
        bus.cpuReq = 1'b0;
        break;
      end
      if (lat == poke) begin
        bus.cpuWr = 1'b1; bus.cpuAddr = 16'h4444; bus.cpuWdata = 16'h5555;
      end else if (lat == poke + 1) begin
        bus.cpuWr = wr; bus.cpuAddr = addr; bus.cpuWdata = data;
      end
    end
  endtask

  task automatic check_beat(input string tag, input int idx, input logic w, input logic [15:0] a, input logic [15:0] d);
    if (idx < beats.size()) check(tag, 64'(beats[idx]), 64'({w, a, d}));
    else check(tag, 64'(idx), 64'(beats.size()));
  endtask

  int          lat, base, mq0, wc0;
  logic [15:0] rd;

  initial begin
    bus.cpuReq = 1'b0; bus.cpuWr = 1'b0; bus.cpuAddr = '0; bus.cpuWdata = '0;
    for (int i = 0; i < 4; i++) begin
      mem[(16'h1230 >> 1) + i] = 16'h00A0 + 16'(i);
      mem[(16'h5630 >> 1) + i] = 16'h00B0 + 16'(i);
      mem[(16'h7808 >> 1) + i] = 16'h00C0 + 16'(i);
      mem[(16'h9A30 >> 1) + i] = 16'h00D0 + 16'(i);
    end

    repeat (3) @(posedge clk);
    #1;
    check("rst_cpuRdata", 64'(bus.cpuRdata), 64'(0));
    check("rst_cpuDone", 64'(bus.cpuDone), 64'(0));
    check("rst_cacheWr", 64'(bus.cacheWr), 64'(0));
    check("rst_cacheTag", 64'(bus.cacheTag), 64'(0));
    check("rst_cacheBlock", bus.cacheBlock, 64'(0));
    check("rst_cacheDirty", 64'(bus.cacheDirty), 64'(0));
    check("rst_memReq", 64'(bus.memReq), 64'(0));
    check("rst_memWr", 64'(bus.memWr), 64'(0));
    check("rst_memAddr", 64'(bus.memAddr), 64'(0));
    check("rst_memWdata", 64'(bus.memWdata), 64'(0));
    check("rst_cacheIndex", 64'(bus.cacheIndex), 64'(0));
    rst = 1'b0;
    @(posedge clk); #1;

    // Clean miss read 0x1234
    base = beats.size();
    do_req(1'b0, 16'h1234, 16'h0, -10, lat, rd);
    check("miss_lat", 64'(lat), 64'(8));
    check("miss_rdata", 64'(rd), 64'h00A2);
    check("miss_beats", 64'(beats.size() - base), 64'(4));
    for (int i = 0; i < 4; i++) check_beat("fill_beat", base + i, 1'b0, 16'h1230 + 16'(2 * i), 16'h0);
    check("install_tag", 64'(last_tag), 64'h12);
    check("install_dirty", 64'(last_dirty), 64'(0));

    // Write hit 0xBEEF -> 0x1236
    mq0 = memreq_cycles;
    do_req(1'b1, 16'h1236, 16'hBEEF, -10, lat, rd);
    check("whit_lat", 64'(lat), 64'(2));
    check("whit_block", last_block, 64'hBEEF_00A2_00A1_00A0);
    check("whit_dirty", 64'(last_dirty), 64'(1));
    check("whit_memreq", 64'(memreq_cycles - mq0), 64'(0));

    // Dirty miss read 0x5634
    base = beats.size();
    do_req(1'b0, 16'h5634, 16'h0, -10, lat, rd);
    check("dmiss_lat", 64'(lat), 64'(12));
    check("dmiss_rdata", 64'(rd), 64'h00B2);
    check("dmiss_beats", 64'(beats.size() - base), 64'(8));
    check_beat("evict0", base + 0, 1'b1, 16'h1230, 16'h00A0);
    check_beat("evict1", base + 1, 1'b1, 16'h1232, 16'h00A1);
    check_beat("evict2", base + 2, 1'b1, 16'h1234, 16'h00A2);
    check_beat("evict3", base + 3, 1'b1, 16'h1236, 16'hBEEF);
    for (int i = 0; i < 4; i++) check_beat("dfill_beat", base + 4 + i, 1'b0, 16'h5630 + 16'(2 * i), 16'h0);

    // Clean miss with 3-cycle ack stall on every beat
    delay = 3; check_stable = 1'b1;
    do_req(1'b0, 16'h7808, 16'h0, -10, lat, rd);
    check("stall_lat", 64'(lat), 64'(20));
    check("stall_rdata", 64'(rd), 64'h00C0);
    delay = 0; check_stable = 1'b0;

    // Reset during FILL beat 2 of a read of 0x1234
    wc0 = wr_count;
    bus.cpuReq = 1'b1; bus.cpuWr = 1'b0; bus.cpuAddr = 16'h1234;
    repeat (4) @(posedge clk);
    #1;
    check("abort_beat2_addr", 64'(bus.memAddr), 64'h1234);
    rst = 1'b1;
    @(posedge clk); #1;
    bus.cpuReq = 1'b0; bus.cpuAddr = 16'h00F8;
    #1;
    check("abort_memReq", 64'(bus.memReq), 64'(0));
    check("abort_cacheWr", 64'(bus.cacheWr), 64'(0));
    check("abort_cpuDone", 64'(bus.cpuDone), 64'(0));
    check("abort_idle_index", 64'(bus.cacheIndex), 64'd31);
    check("abort_no_write", 64'(wr_count - wc0), 64'(0));
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    base = beats.size();
    do_req(1'b0, 16'h1234, 16'h0, -10, lat, rd);
    check("post_rst_lat", 64'(lat), 64'(8));
    check("post_rst_rdata", 64'(rd), 64'h00A2);
    check("post_rst_beats", 64'(beats.size() - base), 64'(4));

    // Dirty line, then miss with a stray request change during EVICT
    do_req(1'b1, 16'h1230, 16'h1111, -10, lat, rd);
    check("w2_lat", 64'(lat), 64'(2));
    base = beats.size();
    do_req(1'b0, 16'h9A32, 16'h0, 3, lat, rd);
    check("poke_lat", 64'(lat), 64'(12));
    check("poke_rdata", 64'(rd), 64'h00D1);
    check_beat("poke_evict0", base + 0, 1'b1, 16'h1230, 16'h1111);
    check_beat("poke_evict3", base + 3, 1'b1, 16'h1236, 16'h00A3);
    check_beat("poke_fill0", base + 4, 1'b0, 16'h9A30, 16'h0);
    check("poke_install_block", last_block, 64'h00D3_00D2_00D1_00D0);
    check("poke_install_tag", 64'(last_tag), 64'h9A);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
